// File: rtl/z1060_flop_pkg.sv
// rtl/z1060_flop_pkg.sv - Z1060 flop slice types: mode enum, init values, FSM states.
// READBACK state exists only with CFG_FLOP_SLICE_READBACK_EN.
package z1060_flop_pkg;

   localparam int MODEW = 3;

   typedef enum logic [2:0] {
      MODE_DFF   = 3'd0,
      MODE_DFFE  = 3'd1,
      MODE_DFFH  = 3'd2,
      MODE_DFFL  = 3'd3,
      MODE_DFFR  = 3'd4,
      MODE_DFFEH = 3'd5,
      MODE_DFFEL = 3'd6,
      MODE_DFFER = 3'd7
   } mode_e;

   typedef enum logic [1:0] {
      ST_UNCFG  = 2'd0,
      ST_LOAD   = 2'd1,
`ifdef CFG_FLOP_SLICE_READBACK_EN
      ST_ACTIVE = 2'd2,
      ST_READBACK = 2'd3
`else
      ST_ACTIVE = 2'd2
`endif
   } state_e;

   // Also the value a sync set/reset mode forces while r is low.
   function automatic logic mode_init(input mode_e mode);
      return (mode == MODE_DFFH) || (mode == MODE_DFFEH);
   endfunction

endpackage

// File: rtl/cfg_flop_cell.sv
// rtl/cfg_flop_cell.sv - One user flop whose primitive type is chosen by a 3-bit mode.
module cfg_flop_cell
   import z1060_flop_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  mode_e mode,
   input  logic  commit,
   input  logic  init,
   input  logic  d,
   input  logic  e,
   input  logic  r,
   output logic  q
);

   logic q_q;
   logic q_d;
   logic async_m;
   logic sync_m;
   logic en_m;

   always_comb begin
      async_m = (mode == MODE_DFFR) || (mode == MODE_DFFER);
      sync_m  = mode inside {MODE_DFFH, MODE_DFFL, MODE_DFFEH, MODE_DFFEL};
      en_m    = mode inside {MODE_DFFE, MODE_DFFEH, MODE_DFFEL, MODE_DFFER};
      q_d     = q_q;
      if (commit) begin
         q_d = init;
      end else if ((async_m || sync_m) && !r) begin
         q_d = sync_m ? mode_init(mode) : 1'b0;
      end else if (!en_m || e) begin
         q_d = d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   // Async clear is seen on q without waiting for an edge.
   assign q = (async_m && !r) ? 1'b0 : q_q;

endmodule

// File: rtl/cfg_flop_slice.sv
// rtl/cfg_flop_slice.sv - Z1060 configurable flop slice with serial mode load.
// Optional mode readback port enabled by CFG_FLOP_SLICE_READBACK_EN.
module cfg_flop_slice #(
   parameter int NFLOPS = 8,
   parameter int MODEW  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_start,
   input  logic              cfg_valid,
   input  logic              cfg_bit,
   output logic              cfg_ready,
   output logic              cfg_done,
   output logic              configured,
   input  logic [NFLOPS-1:0] d,
   input  logic [NFLOPS-1:0] e,
   input  logic [NFLOPS-1:0] r,
   output logic [NFLOPS-1:0] q
`ifdef CFG_FLOP_SLICE_READBACK_EN
   ,
   input  logic              rb_req,
   output logic              rb_valid,
   output logic              rb_bit,
   input  logic              rb_ready
`endif
);

   import z1060_flop_pkg::*;

   localparam int NBITS = NFLOPS * MODEW;
   localparam int CNTW  = $clog2(NBITS + 1);
   localparam logic [CNTW-1:0] LAST = CNTW'(NBITS - 1);

   state_e            state_q;
   logic [NBITS-1:0]  shadow_q;
   logic [NBITS-1:0]  mode_q;
   logic [CNTW-1:0]   cnt_q;
   logic [CNTW-1:0]   cnt_d;
   logic              cfg_ready_q;
   logic              cfg_done_q;
   logic              configured_q;
   logic              commit_q;
   mode_e             cell_mode [NFLOPS];
   logic [NFLOPS-1:0] cell_init;
   logic [NFLOPS-1:0] cell_d;
`ifdef CFG_FLOP_SLICE_READBACK_EN
   logic              rb_valid_q;
   logic              rb_bit_q;
`endif

   assign cnt_d = cnt_q + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_UNCFG;
         shadow_q     <= '0;
         cnt_q        <= '0;
         cfg_ready_q  <= 1'b0;
         cfg_done_q   <= 1'b0;
         configured_q <= 1'b0;
         commit_q     <= 1'b0;
`ifdef CFG_FLOP_SLICE_READBACK_EN
         rb_valid_q   <= 1'b0;
         rb_bit_q     <= 1'b0;
`endif
      end else begin
         cfg_done_q <= 1'b0;
         commit_q   <= 1'b0;
         if (cfg_start) begin
            state_q     <= ST_LOAD;
            cnt_q       <= '0;
            shadow_q    <= '0;
            cfg_ready_q <= 1'b1;
`ifdef CFG_FLOP_SLICE_READBACK_EN
            rb_valid_q  <= 1'b0;
`endif
         end else begin
            case (state_q)
               ST_LOAD: begin
                  if (cfg_valid && cfg_ready_q) begin
                     shadow_q <= {cfg_bit, shadow_q[NBITS-1:1]};
                     if (cnt_q == LAST) begin
                        cnt_q        <= '0;
                        cfg_ready_q  <= 1'b0;
                        cfg_done_q   <= 1'b1;
                        commit_q     <= 1'b1;
                        configured_q <= 1'b1;
                        state_q      <= ST_ACTIVE;
                     end else begin
                        cnt_q <= cnt_d;
                     end
                  end
               end
`ifdef CFG_FLOP_SLICE_READBACK_EN
               // Wait out a pending commit so readback shows the new modes.
               ST_ACTIVE: begin
                  if (rb_req && !commit_q) begin
                     state_q    <= ST_READBACK;
                     cnt_q      <= '0;
                     rb_valid_q <= 1'b1;
                     rb_bit_q   <= mode_q[0];
                  end
               end
               ST_READBACK: begin
                  if (rb_valid_q && rb_ready) begin
                     if (cnt_q == LAST) begin
                        cnt_q      <= '0;
                        rb_valid_q <= 1'b0;
                        state_q    <= ST_ACTIVE;
                     end else begin
                        cnt_q    <= cnt_d;
                        rb_bit_q <= mode_q[cnt_d];
                     end
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_q <= '0;
      end else if (commit_q) begin
         mode_q <= shadow_q;
      end
   end

   // Unconfigured cells sit in mode 0 with d forced low, so q holds 0.
   always_comb begin
      for (int i = 0; i < NFLOPS; i++) begin
         cell_mode[i] = mode_e'(mode_q[i*MODEW +: MODEW]);
         cell_init[i] = mode_init(mode_e'(shadow_q[i*MODEW +: MODEW]));
         cell_d[i]    = d[i] & configured_q;
      end
   end

   for (genvar i = 0; i < NFLOPS; i++) begin : g_cell
      cfg_flop_cell u_cell (
         .clk    (clk),
         .rst_n  (rst_n),
         .mode   (cell_mode[i]),
         .commit (commit_q),
         .init   (cell_init[i]),
         .d      (cell_d[i]),
         .e      (e[i]),
         .r      (r[i]),
         .q      (q[i])
      );
   end

   assign cfg_ready  = cfg_ready_q;
   assign cfg_done   = cfg_done_q;
   assign configured = configured_q;
`ifdef CFG_FLOP_SLICE_READBACK_EN
   assign rb_valid   = rb_valid_q;
   assign rb_bit     = rb_bit_q;
`endif

endmodule

// File: tb/tb_cfg_flop_slice.sv
// tb/tb_cfg_flop_slice.sv - Scoreboard bench for cfg_flop_slice with a behavioural model.
module tb_cfg_flop_slice;

   localparam int N  = 8;
   localparam int NB = N * 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cfg_start = 1'b0;
   logic         cfg_valid = 1'b0;
   logic         cfg_bit = 1'b0;
   logic [N-1:0] d = '0;
   logic [N-1:0] e = '0;
   logic [N-1:0] r = '1;
   logic         cfg_ready;
   logic         cfg_done;
   logic         configured;
   logic [N-1:0] q;
`ifdef CFG_FLOP_SLICE_READBACK_EN
   logic         rb_req = 1'b0;
   logic         rb_ready = 1'b0;
   logic         rb_valid;
   logic         rb_bit;
`endif

   cfg_flop_slice #(.NFLOPS(N), .MODEW(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_start  (cfg_start),
      .cfg_valid  (cfg_valid),
      .cfg_bit    (cfg_bit),
      .cfg_ready  (cfg_ready),
      .cfg_done   (cfg_done),
      .configured (configured),
      .d          (d),
      .e          (e),
      .r          (r),
      .q          (q)
`ifdef CFG_FLOP_SLICE_READBACK_EN
      ,
      .rb_req     (rb_req),
      .rb_valid   (rb_valid),
      .rb_bit     (rb_bit),
      .rb_ready   (rb_ready)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] q;
      logic         rdy;
      logic         done;
      logic         cfgd;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass = 0;
   int   n_total = 0;
   bit   force_ones = 1'b0;

   // Behavioural model: 0 = unconfigured, 1 = loading, 2 = active.
   int   m_st = 0;
   bit   m_bits[$];
   int   m_mode[N];
   int   m_pend[N];
   bit   m_q[N];
   bit   m_commit = 1'b0;
   bit   m_done = 1'b0;
   bit   m_cfgd = 1'b0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endfunction

   function automatic bit flop_next(input int m, input bit qo, input bit dd, input bit ee, input bit rr);
      case (m)
         0:       return dd;
         1:       return ee ? dd : qo;
         2:       return !rr ? 1'b1 : dd;
         3, 4:    return !rr ? 1'b0 : dd;
         5:       return !rr ? 1'b1 : (ee ? dd : qo);
         default: return !rr ? 1'b0 : (ee ? dd : qo);
      endcase
   endfunction

   function automatic void model_edge();
      bit nq[N];
      bit c_next = 1'b0;
      if (!rst_n) begin
         m_st = 0;
         m_bits.delete();
         m_commit = 1'b0;
         m_done = 1'b0;
         m_cfgd = 1'b0;
         for (int i = 0; i < N; i++) begin
            m_mode[i] = 0;
            m_q[i] = 1'b0;
         end
         return;
      end
      for (int i = 0; i < N; i++) begin
         if (m_commit) nq[i] = (m_pend[i] == 2) || (m_pend[i] == 5);
         else if (!m_cfgd) nq[i] = 1'b0;
         else nq[i] = flop_next(m_mode[i], m_q[i], d[i], e[i], r[i]);
      end
      if (m_commit) m_mode = m_pend;
      m_q = nq;
      m_done = 1'b0;
      if (cfg_start) begin
         m_st = 1;
         m_bits.delete();
      end else if (m_st == 1 && cfg_valid) begin
         m_bits.push_back(cfg_bit);
         if (m_bits.size() == NB) begin
            for (int i = 0; i < N; i++)
               m_pend[i] = int'(m_bits[3*i]) + 2 * int'(m_bits[3*i+1]) + 4 * int'(m_bits[3*i+2]);
            c_next = 1'b1;
            m_done = 1'b1;
            m_cfgd = 1'b1;
            m_st = 2;
            m_bits.delete();
         end
      end
      m_commit = c_next;
   endfunction

   function automatic void push_exp();
      exp_t x;
      for (int i = 0; i < N; i++)
         x.q[i] = ((m_mode[i] == 4 || m_mode[i] == 7) && !r[i]) ? 1'b0 : m_q[i];
      x.rdy  = (m_st == 1);
      x.done = m_done;
      x.cfgd = m_cfgd;
      exp_q.push_back(x);
   endfunction

   task automatic cyc(input logic cs, input logic cv, input logic cb,
                      input logic [N-1:0] dd, input logic [N-1:0] ee, input logic [N-1:0] rr);
      cfg_start = cs;
      cfg_valid = cv;
      cfg_bit   = cb;
      d = dd;
      e = ee;
      r = rr;
      push_exp();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic rcyc(input logic cs, input logic cv, input logic cb);
      logic [N-1:0] dd;
      dd = force_ones ? '1 : N'($urandom);
      cyc(cs, cv, cb, dd, N'($urandom), N'($urandom | $urandom));
   endtask

   // Sends the first nbits of the mode stream; gap_pct of cycles drop cfg_valid.
   task automatic load(input int modes[N], input int nbits, input int gap_pct);
      bit bits[$];
      bit gap;
      for (int i = 0; i < N; i++)
         for (int b = 0; b < 3; b++) bits.push_back(modes[i][b]);
      rcyc(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < nbits; k++) begin
         do begin
            gap = ($urandom_range(99) < gap_pct);
            rcyc(1'b0, !gap, gap ? 1'($urandom) : bits[k]);
         end while (gap);
      end
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            chk("q", 32'(q), 32'(x.q));
            chk("cfg_ready", 32'(cfg_ready), 32'(x.rdy));
            chk("cfg_done", 32'(cfg_done), 32'(x.done));
            chk("configured", 32'(configured), 32'(x.cfgd));
         end
      end
   end

   initial begin : stim
      int md[N];
      rst_n = 1'b0;
      @(posedge clk);
      model_edge();
      #1;
      cyc(1'b0, 1'b1, 1'b1, '1, '1, '1);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) rcyc(1'b0, 1'b1, 1'($urandom));

      md = '{1, 2, 0, 0, 0, 0, 0, 0};
      load(md, NB, 0);
      cyc(1'b0, 1'b0, 1'b0, 8'h01, 8'h00, 8'hFF);
      cyc(1'b0, 1'b0, 1'b0, 8'h01, 8'h00, 8'hFF);
      cyc(1'b0, 1'b0, 1'b0, 8'h01, 8'h01, 8'hFF);
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF);

      md = '{5, 7, 0, 0, 0, 0, 0, 0};
      load(md, NB, 20);
      cyc(1'b0, 1'b0, 1'b0, 8'h02, 8'h02, 8'hFF);
      cyc(1'b0, 1'b0, 1'b0, 8'h02, 8'h02, 8'hFF);
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFC);
      cyc(1'b0, 1'b0, 1'b0, 8'h02, 8'h00, 8'hFF);

      md = '{3, 3, 3, 3, 3, 3, 3, 3};
      load('{6, 6, 6, 6, 6, 6, 6, 6}, 10, 0);
      load(md, NB, 0);
      cyc(1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00);
      cyc(1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 8'hF0);

      md = '{0, 0, 0, 0, 0, 0, 0, 0};
      force_ones = 1'b1;
      load(md, NB, 10);
      for (int k = 0; k < 3; k++) rcyc(1'b0, 1'b0, 1'b0);
      force_ones = 1'b0;

      for (int it = 0; it < 12; it++) begin
         for (int i = 0; i < N; i++) md[i] = $urandom_range(7);
         if ($urandom_range(3) == 0) load(md, $urandom_range(NB - 1), 25);
         load(md, NB, 25);
         for (int k = 0; k < 30; k++) rcyc(1'b0, 1'($urandom), 1'($urandom));
      end

`ifdef CFG_FLOP_SLICE_READBACK_EN
      begin : readback
         logic [NB-1:0] pat;
         bit            rb_exp[$];
         int            budget;
         pat = 24'hA5A5A5;
         for (int i = 0; i < N; i++) md[i] = int'(pat[3*i +: 3]);
         for (int k = 0; k < NB; k++) rb_exp.push_back(pat[k]);
         load(md, NB, 0);
         rcyc(1'b0, 1'b0, 1'b0);
         rcyc(1'b0, 1'b0, 1'b0);
         rb_req = 1'b1;
         rcyc(1'b0, 1'b0, 1'b0);
         rb_req = 1'b0;
         budget = 0;
         while (rb_exp.size() != 0 && budget < 100) begin
            rb_ready = budget[0];
            if (rb_valid && rb_ready) chk("rb_bit", 32'(rb_bit), 32'(rb_exp.pop_front()));
            rcyc(1'b0, 1'b0, 1'b0);
            budget++;
         end
         rb_ready = 1'b0;
         chk("rb_remaining", 32'(rb_exp.size()), 32'd0);
         chk("rb_valid_end", 32'(rb_valid), 32'd0);
         md = '{2, 2, 2, 2, 2, 2, 2, 2};
         load(md, NB, 0);
         for (int k = 0; k < 4; k++) rcyc(1'b0, 1'b0, 1'b0);
      end
`endif

      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
